// File: rtl/luz_arbiter.sv
// Round-robin arbiter sharing one light between N_REQ debounced push-buttons.
// Each grant lights sLuz for ON_CYCLES; the owner can cancel early by pressing again.
module luz_arbiter #(
    parameter int N_REQ           = 4,
    parameter int OWNER_W         = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ON_CYCLES       = 16,
    parameter int CNT_W           = 8
) (
    input  logic               sClk,
    input  logic               sReset,
    input  logic [N_REQ-1:0]   sButton,
    output logic               sLuz,
    output logic [OWNER_W-1:0] sOwner,
    output logic               sBusy,
    output logic [N_REQ-1:0]   sPending
);

    localparam logic [CNT_W-1:0]   DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   DEB_MAX   = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]   ON_LOAD   = CNT_W'(ON_CYCLES - 1);
    localparam logic [OWNER_W-1:0] OWNER_RST = OWNER_W'(N_REQ - 1);

    typedef enum logic [1:0] {IDLE, ON, RELEASE} stateT;

    stateT              state;
    logic [CNT_W-1:0]   timer;
    logic [N_REQ-1:0]   debRise;
    logic [N_REQ-1:0]   clrMask;
    logic [OWNER_W-1:0] winner;
    logic [OWNER_W-1:0] cand;
    logic               found;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : gReq
            logic             sync1;
            logic             sync2;
            logic             level;
            logic             levelDly;
            logic [CNT_W-1:0] cnt;

            always_ff @(posedge sClk or negedge sReset) begin
                if (!sReset) begin
                    sync1    <= 1'b0;
                    sync2    <= 1'b0;
                    level    <= 1'b0;
                    levelDly <= 1'b0;
                    cnt      <= '0;
                end else begin
                    sync1    <= sButton[gi];
                    sync2    <= sync1;
                    levelDly <= level;
                    if (!sync2) begin
                        cnt   <= '0;
                        level <= 1'b0;
                    end else if (cnt != DEB_MAX) begin
                        // level rises on the same edge the counter saturates
                        cnt <= cnt + 1'b1;
                        if (cnt == DEB_LAST) begin
                            level <= 1'b1;
                        end
                    end
                end
            end

            assign debRise[gi] = level & ~levelDly;
        end
    endgenerate

    // Search for the next pending requester starting just after the current owner.
    always_comb begin
        winner = sOwner;
        found  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = OWNER_W'((int'(sOwner) + k) % N_REQ);
            if (!found && sPending[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        clrMask = '0;
        case (state)
            IDLE:    if (found) clrMask[winner] = 1'b1;
            ON:      if (sPending[sOwner]) clrMask[sOwner] = 1'b1;
            default: clrMask = '0;
        endcase
    end

    always_ff @(posedge sClk or negedge sReset) begin
        if (!sReset) begin
            state    <= IDLE;
            timer    <= '0;
            sLuz     <= 1'b0;
            sBusy    <= 1'b0;
            sOwner   <= OWNER_RST;
            sPending <= '0;
        end else begin
            sPending <= (sPending & ~clrMask) | debRise;
            case (state)
                IDLE: begin
                    if (found) begin
                        state  <= ON;
                        sLuz   <= 1'b1;
                        sBusy  <= 1'b1;
                        sOwner <= winner;
                        timer  <= ON_LOAD;
                    end
                end
                ON: begin
                    // owner re-press and expiry both end the grant in one step
                    if (sPending[sOwner] || timer == '0) begin
                        state <= RELEASE;
                        sLuz  <= 1'b0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                    sBusy <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    sLuz  <= 1'b0;
                    sBusy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_luz_arbiter.sv
// Directed bench for luz_arbiter: reset, latency, debounce, round-robin order,
// owner cancel and cancel-at-expiry.
module tb_luz_arbiter;

    logic       sClk;
    logic       sReset;
    logic [3:0] sButton;
    logic       sLuz;
    logic [1:0] sOwner;
    logic       sBusy;
    logic [3:0] sPending;

    int checks   = 0;
    int failures = 0;

    luz_arbiter #(
        .N_REQ(4), .OWNER_W(2), .DEBOUNCE_CYCLES(4), .ON_CYCLES(16), .CNT_W(8)
    ) dut (
        .sClk(sClk),
        .sReset(sReset),
        .sButton(sButton),
        .sLuz(sLuz),
        .sOwner(sOwner),
        .sBusy(sBusy),
        .sPending(sPending)
    );

    initial sClk = 1'b0;
    always #5 sClk = ~sClk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sClk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset and idle
        sReset  = 1'b0;
        sButton = 4'b0000;
        tick(3);
        chk("rst_luz", 16'(sLuz), 16'd0);
        chk("rst_busy", 16'(sBusy), 16'd0);
        chk("rst_pending", 16'(sPending), 16'd0);
        chk("rst_owner", 16'(sOwner), 16'd3);
        sReset = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            tick(1);
            chk("idle_all", 16'({sLuz, sBusy, sPending, sOwner}), 16'({1'b0, 1'b0, 4'b0000, 2'd3}));
        end

        // Single held press: sLuz high after edge 8 for 16 cycles, one grant only
        sButton = 4'b0001;
        for (int k = 1; k <= 30; k++) begin
            tick(1);
            chk("hold_luz", 16'(sLuz), 16'(k >= 8 && k <= 23));
            chk("hold_busy", 16'(sBusy), 16'(k >= 8 && k <= 24));
            if (k == 7) chk("hold_pend7", 16'(sPending), 16'h1);
            if (k == 8) begin
                chk("hold_owner", 16'(sOwner), 16'd0);
                chk("hold_pend8", 16'(sPending), 16'h0);
            end
            if (k == 20) sButton = 4'b0000;
        end
        chk("hold_pend_end", 16'(sPending), 16'h0);

        // Short glitch on button 2 is ignored
        tick(5);
        sButton = 4'b0100;
        tick(2);
        sButton = 4'b0000;
        for (int k = 1; k <= 15; k++) begin
            tick(1);
            chk("glitch_pend", 16'(sPending), 16'h0);
            chk("glitch_luz", 16'(sLuz), 16'd0);
        end

        // Four-cycle press is accepted; reset asserted in ON cycle 5
        sButton = 4'b0100;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            if (k == 4) sButton = 4'b0000;
            if (k == 6) chk("press4_pend6", 16'(sPending), 16'h0);
            if (k == 7) chk("press4_pend7", 16'(sPending), 16'h4);
            if (k == 8) begin
                chk("press4_luz", 16'(sLuz), 16'd1);
                chk("press4_owner", 16'(sOwner), 16'd2);
            end
            if (k == 12) chk("press4_luz12", 16'(sLuz), 16'd1);
        end
        sReset = 1'b0;
        #1;
        chk("midrst_luz", 16'(sLuz), 16'd0);
        chk("midrst_busy", 16'(sBusy), 16'd0);
        chk("midrst_owner", 16'(sOwner), 16'd3);
        chk("midrst_pend", 16'(sPending), 16'h0);
        tick(2);
        sReset = 1'b1;

        // Three simultaneous requesters served in order 0, 1, 3
        sButton = 4'b1011;
        for (int k = 1; k <= 62; k++) begin
            tick(1);
            if (k == 10) sButton = 4'b0000;
            chk("rr_luz", 16'(sLuz), 16'((k >= 8 && k <= 23) || (k >= 26 && k <= 41) || (k >= 44 && k <= 59)));
            if (k == 7) chk("rr_pend7", 16'(sPending), 16'hB);
            if (k == 8) begin
                chk("rr_owner0", 16'(sOwner), 16'd0);
                chk("rr_pend8", 16'(sPending), 16'hA);
            end
            if (k == 26) begin
                chk("rr_owner1", 16'(sOwner), 16'd1);
                chk("rr_pend26", 16'(sPending), 16'h8);
            end
            if (k == 44) begin
                chk("rr_owner3", 16'(sOwner), 16'd3);
                chk("rr_pend44", 16'(sPending), 16'h0);
            end
        end

        // Owner 1 cancels early; grant then passes to requester 2
        tick(3);
        sButton = 4'b0110;
        for (int k = 1; k <= 45; k++) begin
            tick(1);
            if (k == 7) chk("cancel_pend7", 16'(sPending), 16'h6);
            if (k == 8) begin
                chk("cancel_owner1", 16'(sOwner), 16'd1);
                chk("cancel_luz8", 16'(sLuz), 16'd1);
                chk("cancel_pend8", 16'(sPending), 16'h4);
            end
            if (k == 19) begin
                chk("cancel_luz19", 16'(sLuz), 16'd1);
                chk("cancel_pend19", 16'(sPending), 16'h6);
            end
            if (k == 20) begin
                chk("cancel_luz20", 16'(sLuz), 16'd0);
                chk("cancel_busy20", 16'(sBusy), 16'd1);
                chk("cancel_pend20", 16'(sPending), 16'h4);
            end
            if (k == 21) begin
                chk("cancel_luz21", 16'(sLuz), 16'd0);
                chk("cancel_busy21", 16'(sBusy), 16'd0);
            end
            if (k == 22) begin
                chk("cancel_luz22", 16'(sLuz), 16'd1);
                chk("cancel_owner2", 16'(sOwner), 16'd2);
                chk("cancel_pend22", 16'(sPending), 16'h0);
            end
            if (k == 37) chk("cancel_luz37", 16'(sLuz), 16'd1);
            if (k == 38) chk("cancel_luz38", 16'(sLuz), 16'd0);
            if (k == 10) sButton = 4'b0000;
            if (k == 12) sButton = 4'b0010;
            if (k == 22) sButton = 4'b0000;
        end

        // Owner re-press lands on the timer==0 cycle: single release, no re-grant
        sButton = 4'b1000;
        for (int k = 1; k <= 36; k++) begin
            tick(1);
            if (k == 8) begin
                chk("expcan_owner", 16'(sOwner), 16'd3);
                chk("expcan_luz8", 16'(sLuz), 16'd1);
            end
            if (k == 22) chk("expcan_pend22", 16'(sPending), 16'h0);
            if (k == 23) begin
                chk("expcan_pend23", 16'(sPending), 16'h8);
                chk("expcan_luz23", 16'(sLuz), 16'd1);
            end
            if (k == 24) begin
                chk("expcan_pend24", 16'(sPending), 16'h0);
                chk("expcan_busy24", 16'(sBusy), 16'd1);
            end
            if (k == 25) chk("expcan_busy25", 16'(sBusy), 16'd0);
            if (k >= 24) chk("expcan_luz_off", 16'(sLuz), 16'd0);
            if (k == 36) begin
                chk("expcan_pend_end", 16'(sPending), 16'h0);
                chk("expcan_owner_end", 16'(sOwner), 16'd3);
            end
            if (k == 10) sButton = 4'b0000;
            if (k == 16) sButton = 4'b1000;
            if (k == 26) sButton = 4'b0000;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
